// File: rtl/ol_score_buffer.sv
// ol_score_buffer: gathers one frame of output-layer scores into a parallel
// buffer for the argmax stage, waits out the argmax latency, then offers the
// winning class index downstream with a valid/ready handshake.
module ol_score_buffer #(
    parameter int N_CLASS    = 10,
    parameter int DW         = 32,
    parameter int FM_LATENCY = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic [DW-1:0] out_0,
    output logic [DW-1:0] out_1,
    output logic [DW-1:0] out_2,
    output logic [DW-1:0] out_3,
    output logic [DW-1:0] out_4,
    output logic [DW-1:0] out_5,
    output logic [DW-1:0] out_6,
    output logic [DW-1:0] out_7,
    output logic [DW-1:0] out_8,
    output logic [DW-1:0] out_9,
    input  logic [3:0]    fm_result,
    output logic [3:0]    result,
    output logic          result_valid,
    input  logic          result_ready,
    output logic          err_frame
);

    localparam logic [3:0] LAST_IDX = 4'(N_CLASS - 1);
    localparam logic [3:0] LAT_M1   = 4'(FM_LATENCY - 1);

    typedef enum logic [1:0] {FILL, SETTLE, HOLD} state_t;

    state_t        state;
    logic [3:0]    idx;
    logic [3:0]    cnt;
    logic          discard;
    logic [DW-1:0] score_buf [N_CLASS];

    // Beats are only taken while filling; reset forces the handshake low.
    assign in_ready = (state == FILL) && rst;

    assign out_0 = score_buf[0];
    assign out_1 = score_buf[1];
    assign out_2 = score_buf[2];
    assign out_3 = score_buf[3];
    assign out_4 = score_buf[4];
    assign out_5 = score_buf[5];
    assign out_6 = score_buf[6];
    assign out_7 = score_buf[7];
    assign out_8 = score_buf[8];
    assign out_9 = score_buf[9];

    // Frame FSM: fill the buffer, let argmax settle, hold the result until taken.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= FILL;
            idx          <= '0;
            cnt          <= '0;
            discard      <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            err_frame    <= 1'b0;
            for (int i = 0; i < N_CLASS; i++) score_buf[i] <= '0;
        end else begin
            err_frame <= 1'b0;
            case (state)
                FILL: begin
                    // in_ready is implied here: state is FILL and rst is high
                    if (in_valid) begin
                        if (discard) begin
                            // tail of an over-long frame: drop beats until its last
                            if (in_last) discard <= 1'b0;
                        end else begin
                            score_buf[idx] <= in_data;
                            if (idx == LAST_IDX) begin
                                idx <= '0;
                                if (in_last) begin
                                    state <= SETTLE;
                                    cnt   <= '0;
                                end else begin
                                    err_frame <= 1'b1;
                                    discard   <= 1'b1;
                                end
                            end else if (in_last) begin
                                err_frame <= 1'b1;
                                idx       <= '0;
                            end else begin
                                idx <= idx + 4'd1;
                            end
                        end
                    end
                end
                SETTLE: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == LAT_M1) begin
                        result       <= fm_result;
                        result_valid <= 1'b1;
                        state        <= HOLD;
                    end
                end
                HOLD: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        idx          <= '0;
                        state        <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_ol_score_buffer.sv
// Testbench for ol_score_buffer: a behavioural argmax with matching latency
// stands in for PE_findamx; expected class indices go through a queue.
module tb_ol_score_buffer;

    localparam int FM_LATENCY = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        result_ready = 1'b1;
    logic [31:0] in_data = '0;
    logic [3:0]  fm_result;
    logic        in_ready, result_valid, err_frame;
    logic [3:0]  result;
    logic [31:0] outs [10];

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;
    logic        err_seen_at [16];
    logic [3:0]  exp_q [$];

    logic [31:0] base [10] = '{32'h41200000, 32'h41A00000, 32'h41F00000, 32'h42200000,
                               32'h42480000, 32'h42700000, 32'h428C0000, 32'h42A00000,
                               32'h42B40000, 32'h42C80000};
    logic [31:0] fv [10];

    ol_score_buffer #(.N_CLASS(10), .DW(32), .FM_LATENCY(FM_LATENCY)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last),
        .out_0(outs[0]), .out_1(outs[1]), .out_2(outs[2]), .out_3(outs[3]), .out_4(outs[4]),
        .out_5(outs[5]), .out_6(outs[6]), .out_7(outs[7]), .out_8(outs[8]), .out_9(outs[9]),
        .fm_result(fm_result), .result(result), .result_valid(result_valid),
        .result_ready(result_ready), .err_frame(err_frame)
    );

    always #5 clk = ~clk;

    // Argmax stand-in: positive floats order like unsigned ints; first max wins.
    function automatic logic [3:0] amax_f();
        logic [3:0] m = 4'd0;
        for (int i = 1; i < 10; i++) if (outs[i] > outs[m]) m = 4'(i);
        return m;
    endfunction

    // FM_LATENCY-1 register stages so a capture on the FM_LATENCY-th edge sees a settled value.
    logic [3:0] fm_pipe [3];
    always @(posedge clk) begin
        fm_pipe[0] <= amax_f();
        fm_pipe[1] <= fm_pipe[0];
        fm_pipe[2] <= fm_pipe[1];
    end
    assign fm_result = fm_pipe[2];

    // Count err_frame pulses (sampled at the edge, each one-cycle pulse counts once).
    always @(posedge clk) if (err_frame) err_cnt++;

    // Drive nbeats beats from fv (extra beats get filler data), in_last on beat last_at.
    // Ends at the negedge after the final beat's edge with inputs idle.
    task automatic send_frame(input int nbeats, input int last_at);
        for (int b = 0; b < nbeats; b++) begin
            @(negedge clk);
            err_seen_at[b] = err_frame;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL beat_ready beat=%0d in_ready=%b required 1", b, in_ready);
            end
            in_valid = 1'b1;
            in_data  = (b < 10) ? fv[b] : 32'h100 + 32'(b);
            in_last  = (b == last_at - 1);
        end
        @(negedge clk);
        err_seen_at[nbeats] = err_frame;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait for result_valid; lat = cycles after the last beat's edge, -1 on timeout.
    task automatic wait_rv(output int lat);
        lat = 0;
        while (!result_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!result_valid) lat = -1;
    endtask

    // One well-formed frame with result_ready high; expected index is k.
    task automatic run_good_frame(input logic [3:0] k);
        int lat;
        logic [3:0] exp;
        exp_q.push_back(k);
        send_frame(10, 10);
        wait_rv(lat);
        checks++;
        if (lat != FM_LATENCY) begin
            errors++;
            $display("FAIL latency k=%0d got=%0d required %0d", k, lat, FM_LATENCY);
        end
        if (lat >= 0) begin
            exp = exp_q.pop_front();
            checks++;
            if (result !== exp) begin
                errors++;
                $display("FAIL result got=%0d required %0d", result, exp);
            end
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (outs[i] !== fv[i]) begin
                errors++;
                $display("FAIL out_%0d got=%h required %h", i, outs[i], fv[i]);
            end
        end
    endtask

    task automatic load_rotated(input int k);
        fv = base;
        fv[k] = base[9];
        fv[9] = base[k];
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || result_valid !== 1'b0 || err_frame !== 1'b0 || result !== 4'd0) begin
            errors++;
            $display("FAIL reset_ctrl in_ready=%b rv=%b err=%b result=%0d required 0,0,0,0",
                     in_ready, result_valid, err_frame, result);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (outs[i] !== 32'd0) begin
                errors++;
                $display("FAIL reset_out_%0d got=%h required 0", i, outs[i]);
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_full_frame();
        fv = base;
        run_good_frame(4'd9);
        @(negedge clk);
        checks++;
        if (result_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_rv_width rv=%b in_ready=%b required 0,1", result_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int e0 = err_cnt;
        for (int k = 8; k >= 0; k--) begin
            load_rotated(k);
            run_good_frame(4'(k));
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (err_cnt != e0) begin
            errors++;
            $display("FAIL rotated_err pulses=%0d required 0", err_cnt - e0);
        end
    endtask

    task automatic test_back_pressure();
        int lat;
        int bad = 0;
        logic [3:0] exp;
        load_rotated(4);
        result_ready = 1'b0;
        exp_q.push_back(4'd4);
        send_frame(10, 10);
        wait_rv(lat);
        checks++;
        if (lat != FM_LATENCY) begin
            errors++;
            $display("FAIL bp_latency got=%0d required %0d", lat, FM_LATENCY);
        end
        exp = exp_q.pop_front();
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hDEADBEEF;
            @(negedge clk);
            if (result_valid !== 1'b1 || result !== exp || in_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_stall bad_cycles=%0d required 0 (rv=%b result=%0d exp=%0d)",
                     bad, result_valid, result, exp);
        end
        in_valid = 1'b0;
        result_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || result_valid !== 1'b0 || result !== exp) begin
            errors++;
            $display("FAIL bp_release in_ready=%b rv=%b result=%0d required 1,0,%0d",
                     in_ready, result_valid, result, exp);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (outs[i] !== fv[i]) begin
                errors++;
                $display("FAIL bp_out_%0d got=%h required %h", i, outs[i], fv[i]);
            end
        end
    endtask

    task automatic test_short_frame();
        int e0 = err_cnt;
        int seen = 0;
        for (int i = 0; i < 10; i++) fv[i] = 32'h3F800000;
        send_frame(5, 5);
        checks++;
        if (err_seen_at[5] !== 1'b1) begin
            errors++;
            $display("FAIL short_err_pulse err_frame=%b required 1", err_seen_at[5]);
        end
        repeat (10) begin
            @(negedge clk);
            if (result_valid) seen++;
        end
        checks++;
        if (seen != 0 || err_cnt != e0 + 1) begin
            errors++;
            $display("FAIL short_effect rv_cycles=%0d err_pulses=%0d required 0,1", seen, err_cnt - e0);
        end
        load_rotated(3);
        run_good_frame(4'd3);
    endtask

    task automatic test_long_frame();
        int e0 = err_cnt;
        int seen = 0;
        for (int i = 0; i < 10; i++) fv[i] = 32'h200 + 32'(i);
        send_frame(12, 12);
        checks++;
        if (err_seen_at[10] !== 1'b1 || err_seen_at[9] !== 1'b0 ||
            err_seen_at[11] !== 1'b0 || err_seen_at[12] !== 1'b0) begin
            errors++;
            $display("FAIL long_err_timing at9=%b at10=%b at11=%b at12=%b required 0,1,0,0",
                     err_seen_at[9], err_seen_at[10], err_seen_at[11], err_seen_at[12]);
        end
        checks++;
        if (outs[0] !== fv[0] || outs[1] !== fv[1] || outs[9] !== fv[9]) begin
            errors++;
            $display("FAIL long_discard out0=%h out1=%h out9=%h required %h,%h,%h",
                     outs[0], outs[1], outs[9], fv[0], fv[1], fv[9]);
        end
        repeat (8) begin
            @(negedge clk);
            if (result_valid) seen++;
        end
        checks++;
        if (seen != 0 || err_cnt != e0 + 1) begin
            errors++;
            $display("FAIL long_effect rv_cycles=%0d err_pulses=%0d required 0,1", seen, err_cnt - e0);
        end
        load_rotated(7);
        run_good_frame(4'd7);
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        load_rotated(5);
        send_frame(10, 10);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_ready in_ready=%b required 0", in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || result_valid !== 1'b0 || result !== 4'd0) begin
            errors++;
            $display("FAIL mid_rst_ctrl in_ready=%b rv=%b result=%0d required 1,0,0",
                     in_ready, result_valid, result);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (outs[i] !== 32'd0) begin
                errors++;
                $display("FAIL mid_rst_out_%0d got=%h required 0", i, outs[i]);
            end
        end
        repeat (8) begin
            @(negedge clk);
            if (result_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL mid_rst_dropped rv_cycles=%0d required 0", seen);
        end
        load_rotated(2);
        run_good_frame(4'd2);
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_back_to_back();
        test_back_pressure();
        test_short_frame();
        test_long_frame();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover entries=%0d required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
